// File: rtl/multicycle_controller.sv
// Main control FSM and ALU/immediate decoders for the multicycle RV32I core.
// Steps the shared datapath one state per clock and drives every enable and select.
module multicycle_controller #(
    parameter bit BNE_EN       = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t     curState, nextState;
    logic       opKnown;
    logic       pcUpdate, branch;
    logic       irWriteRaw, regWriteRaw, memWriteRaw, doneRaw;
    logic [1:0] aluOp;
    logic       bneSel;

    assign state = curState;

    // Opcodes the controller implements
    always_comb begin
        unique case (op)
            7'b0000011, 7'b0100011, 7'b0110011,
            7'b0010011, 7'b1101111, 7'b1100011: opKnown = 1'b1;
            default:                            opKnown = 1'b0;
        endcase
    end

    // State register, asynchronously returned to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) curState <= FETCH;
        else       curState <= nextState;
    end

    // Next-state sequencing
    always_comb begin
        nextState = FETCH;
        case (curState)
            FETCH:    nextState = DECODE;
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: nextState = MEMADR;
                    7'b0110011:             nextState = EXECUTER;
                    7'b0010011:             nextState = EXECUTEI;
                    7'b1101111:             nextState = JAL;
                    7'b1100011:             nextState = BEQ;
                    default: begin
                        if (ILLEGAL_TRAP) nextState = HALT;
                        else              nextState = FETCH;
                    end
                endcase
            end
            MEMADR:   nextState = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  nextState = MEMWB;
            MEMWB:    nextState = FETCH;
            MEMWRITE: nextState = FETCH;
            EXECUTER: nextState = ALUWB;
            EXECUTEI: nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            JAL:      nextState = ALUWB;
            BEQ:      nextState = FETCH;
            HALT:     nextState = HALT;
            default:  nextState = FETCH;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        memWriteRaw = 1'b0;
        doneRaw     = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        aluOp       = 2'b00;
        illegal     = 1'b0;
        case (curState)
            FETCH: begin
                irWriteRaw = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pcUpdate   = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (!ILLEGAL_TRAP && !opKnown) doneRaw = 1'b1;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc   = 2'b01;
                regWriteRaw = 1'b1;
                doneRaw     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                memWriteRaw = 1'b1;
                doneRaw     = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluOp   = 2'b10;
            end
            ALUWB: begin
                regWriteRaw = 1'b1;
                doneRaw     = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcUpdate = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
                doneRaw = 1'b1;
            end
            HALT:    illegal = 1'b1;
            default: ;
        endcase
    end

    // Write enables are held off for as long as reset is asserted
    assign bneSel     = BNE_EN && (funct3 == 3'b001);
    assign PCWrite    = !reset && (pcUpdate || (branch && (Zero ^ bneSel)));
    assign IRWrite    = !reset && irWriteRaw;
    assign RegWrite   = !reset && regWriteRaw;
    assign MemWrite   = !reset && memWriteRaw;
    assign instr_done = !reset && doneRaw;

    // ALU operation decode
    always_comb begin
        ALUControl = 3'b000;
        case (aluOp)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    // Immediate format decode, independent of state
    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction trace model plus literal pins.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done, illegal;
    logic [3:0] state;

    multicycle_controller #(.BNE_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BR = 5, C_ILL = 6;

    int tests = 0;
    int fails = 0;

    logic       chk = 1'b0;
    logic [3:0] eState;
    logic       ePC, eIR, eReg, eMem, eDone, eIll, eAdr;
    logic [1:0] eRes, eA, eB, eImm;
    logic [2:0] eAlu;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classOf(input logic [6:0] o);
        case (o)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1101111: return C_JAL;
            7'b1100011: return C_BR;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] immOf(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // ALU operation required for an R/I instruction in its execute step
    function automatic logic [2:0] aluOf(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Compare DUT against the model on every checked cycle
    always @(negedge clk) begin
        if (chk) begin
            check("state", state, eState);
            check("PCWrite", 4'(PCWrite), 4'(ePC));
            check("IRWrite", 4'(IRWrite), 4'(eIR));
            check("RegWrite", 4'(RegWrite), 4'(eReg));
            check("MemWrite", 4'(MemWrite), 4'(eMem));
            check("instr_done", 4'(instr_done), 4'(eDone));
            check("illegal", 4'(illegal), 4'(eIll));
            check("AdrSrc", 4'(AdrSrc), 4'(eAdr));
            check("ResultSrc", 4'(ResultSrc), 4'(eRes));
            check("ALUSrcA", 4'(ALUSrcA), 4'(eA));
            check("ALUSrcB", 4'(ALUSrcB), 4'(eB));
            check("ALUControl", 4'(ALUControl), 4'(eAlu));
            check("ImmSrc", 4'(ImmSrc), 4'(eImm));
        end
    end

    // Run one instruction from FETCH for nSteps cycles (-1 = whole instruction).
    // Entered and left just after a rising edge.
    task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int nSteps, input int pinStep,
                            input logic [3:0] pinState, input logic pinPc,
                            input logic [2:0] pinAlu);
        int   c;
        int   seq[$];
        int   len;
        logic last, taken;
        c = classOf(o);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        case (c)
            C_LW:    seq = '{0, 1, 2, 3, 4};
            C_SW:    seq = '{0, 1, 2, 5};
            C_R:     seq = '{0, 1, 6, 7};
            C_I:     seq = '{0, 1, 8, 7};
            C_JAL:   seq = '{0, 1, 9, 7};
            C_BR:    seq = '{0, 1, 10};
            default: seq = '{0, 1, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11};
        endcase
        taken = z ^ (f3 == 3'b001);
        len = (nSteps < 0) ? seq.size() : nSteps;
        for (int s = 0; s < len; s++) begin
            last   = (s == seq.size() - 1);
            eState = 4'(seq[s]);
            eIR    = (s == 0);
            ePC    = (s == 0) || (c == C_JAL && s == 2) || (c == C_BR && last && taken);
            eReg   = last && (c == C_LW || c == C_R || c == C_I || c == C_JAL);
            eMem   = last && (c == C_SW);
            eDone  = last && (c != C_ILL);
            eIll   = (c == C_ILL) && (s >= 2);
            eAdr   = (c == C_LW || c == C_SW) && (s == 3);
            eRes   = (s == 0) ? 2'b10 : ((c == C_LW && last) ? 2'b01 : 2'b00);
            eImm   = immOf(o);
            eAlu   = 3'b000;
            if (s == 2 && (c == C_R || c == C_I)) eAlu = aluOf(o, f3, f7);
            if (s == 2 && c == C_BR)              eAlu = 3'b001;
            eA = 2'b00; eB = 2'b00;
            if (s == 0) begin
                eB = 2'b10;
            end else if (s == 1) begin
                eA = 2'b01; eB = 2'b01;
            end else if (s == 2) begin
                case (c)
                    C_LW, C_SW, C_I: begin eA = 2'b10; eB = 2'b01; end
                    C_R, C_BR:       begin eA = 2'b10; eB = 2'b00; end
                    C_JAL:           begin eA = 2'b01; eB = 2'b10; end
                    default:         ;
                endcase
            end
            chk = 1'b1;
            @(negedge clk);
            #1;
            if (s == pinStep) begin
                check("pinState", state, pinState);
                check("pinPCWrite", 4'(PCWrite), 4'(pinPc));
                check("pinALUControl", 4'(ALUControl), 4'(pinAlu));
            end
            @(posedge clk);
            #1;
        end
        chk = 1'b0;
    endtask

    // Assert reset mid-cycle, check the forced values, release after one edge
    task automatic doReset(input string name);
        chk = 1'b0;
        reset = 1'b1;
        #1;
        check({name, "_state"}, state, 4'd0);
        check({name, "_PCWrite"}, 4'(PCWrite), 4'd0);
        check({name, "_IRWrite"}, 4'(IRWrite), 4'd0);
        check({name, "_RegWrite"}, 4'(RegWrite), 4'd0);
        check({name, "_MemWrite"}, 4'(MemWrite), 4'd0);
        check({name, "_instr_done"}, 4'(instr_done), 4'd0);
        check({name, "_illegal"}, 4'(illegal), 4'd0);
        check({name, "_AdrSrc"}, 4'(AdrSrc), 4'd0);
        check({name, "_ALUSrcB"}, 4'(ALUSrcB), 4'd2);
        check({name, "_ResultSrc"}, 4'(ResultSrc), 4'd2);
        @(posedge clk);
        #1;
        check({name, "_heldState"}, state, 4'd0);
        reset = 1'b0;
        #1;
        check({name, "_relState"}, state, 4'd0);
        check({name, "_relIRWrite"}, 4'(IRWrite), 4'd1);
        check({name, "_relPCWrite"}, 4'(PCWrite), 4'd1);
    endtask

    initial begin
        reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
        #2;
        doReset("por");
        // loads, stores
        runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 4, 4'd4, 1'b0, 3'b000);
        runInstr(7'b0100011, 3'b010, 1'b0, 1'b0, -1, 3, 4'd5, 1'b0, 3'b000);
        // R-type ALU decode
        runInstr(7'b0110011, 3'b000, 1'b1, 1'b0, -1, 2, 4'd6, 1'b0, 3'b001);
        runInstr(7'b0110011, 3'b111, 1'b0, 1'b0, -1, 2, 4'd6, 1'b0, 3'b010);
        runInstr(7'b0110011, 3'b000, 1'b0, 1'b0, -1, 2, 4'd6, 1'b0, 3'b000);
        runInstr(7'b0110011, 3'b010, 1'b0, 1'b0, -1, 2, 4'd6, 1'b0, 3'b101);
        runInstr(7'b0110011, 3'b110, 1'b1, 1'b0, -1, 2, 4'd6, 1'b0, 3'b011);
        // I-type: funct7b5 ignored since op[5]=0
        runInstr(7'b0010011, 3'b000, 1'b1, 1'b0, -1, 2, 4'd8, 1'b0, 3'b000);
        runInstr(7'b0010011, 3'b100, 1'b0, 1'b0, -1, 2, 4'd8, 1'b0, 3'b000);
        // jal
        runInstr(7'b1101111, 3'b000, 1'b0, 1'b0, -1, 2, 4'd9, 1'b1, 3'b000);
        // beq / bne taken and not taken
        runInstr(7'b1100011, 3'b000, 1'b0, 1'b1, -1, 2, 4'd10, 1'b1, 3'b001);
        runInstr(7'b1100011, 3'b000, 1'b0, 1'b0, -1, 2, 4'd10, 1'b0, 3'b001);
        runInstr(7'b1100011, 3'b001, 1'b0, 1'b0, -1, 2, 4'd10, 1'b1, 3'b001);
        runInstr(7'b1100011, 3'b001, 1'b0, 1'b1, -1, 2, 4'd10, 1'b0, 3'b001);
        // reset mid-instruction
        runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, 4, -1, 4'd0, 1'b0, 3'b000);
        doReset("midMemwb");
        runInstr(7'b0100011, 3'b010, 1'b0, 1'b0, 3, -1, 4'd0, 1'b0, 3'b000);
        doReset("midMemwrite");
        runInstr(7'b0110011, 3'b000, 1'b1, 1'b0, 3, -1, 4'd0, 1'b0, 3'b000);
        doReset("midAluwb");
        // illegal opcode: HALT held 10 cycles, then reset recovers
        runInstr(7'b1111111, 3'b000, 1'b0, 1'b0, -1, 11, 4'd11, 1'b0, 3'b000);
        doReset("halt");
        runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 4, 4'd4, 1'b0, 3'b000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
